ga23_sdr_arbiter: RTL and testbench

- Sits directly downstream of the GA23 tilemap layers.
- Merges their toggle-handshake tile-row fetch requests into one toggle-handshake SDRAM port, using round-robin arbitration.
- Returns each 32-bit row word to the requesting layer in a per-layer hold register, so the layer's shifter can read it at its next load.
- One transaction is outstanding at a time.

---
 rtl/ga23_sdr_arbiter_if.sv | 26 ++
 rtl/ga23_sdr_arbiter.sv | 126 ++++++++++++
 tb/tb_ga23_sdr_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ga23_sdr_arbiter_if.sv
// Signal bundle joining the GA23 tilemap layers, the SDRAM row arbiter and the SDRAM port.
// The arbiter takes the slave view; the layers and the SDRAM controller together take the master view.
interface ga23_sdr_arbiter_if #(
  parameter int N_LAYERS = 3,
  parameter int AW       = 22
);
  logic [N_LAYERS-1:0]    layer_req;
  logic [N_LAYERS*AW-1:0] layer_addr;
  logic [N_LAYERS-1:0]    layer_ack;
  logic [N_LAYERS*32-1:0] layer_data;
  logic [AW-1:0]          sdr_addr;
  logic                   sdr_req;
  logic                   sdr_ack;
  logic [31:0]            sdr_data;
  logic                   busy;

  modport slave (
    input  layer_req, layer_addr, sdr_ack, sdr_data,
    output layer_ack, layer_data, sdr_addr, sdr_req, busy
  );

  modport master (
    output layer_req, layer_addr, sdr_ack, sdr_data,
    input  layer_ack, layer_data, sdr_addr, sdr_req, busy
  );
endinterface

// File: rtl/ga23_sdr_arbiter.sv
// Round-robin merge of the GA23 tilemap layers' toggle-handshake row fetches onto one SDRAM port.
// One transaction is outstanding at a time; each returned row word lands in its layer's hold register.
module ga23_sdr_arbiter #(
  parameter int N_LAYERS = 3,
  parameter int AW       = 22
) (
  input  logic               clk,
  input  logic               reset,
  ga23_sdr_arbiter_if.slave  bus
);

  localparam int GW = $clog2(N_LAYERS);
  localparam int RW = GW + 1;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                 r_state;
  state_t                 w_nextState;
  logic [GW-1:0]          r_lastGrant;
  logic [GW-1:0]          r_grant;
  logic [AW-1:0]          r_sdrAddr;
  logic                   r_sdrReq;
  logic [N_LAYERS-1:0]    r_layerAck;
  logic [N_LAYERS*32-1:0] r_layerData;

  logic [N_LAYERS-1:0]    w_pending;
  logic                   w_anyPending;
  logic                   w_ctrlIdle;
  logic [GW-1:0]          w_grantIdx;
  logic [RW-1:0]          w_rotIdx;
  logic [AW-1:0]          w_grantAddr;
  logic                   w_doGrant;
  logic                   w_doComplete;
  logic                   w_busy;

  assign w_pending    = bus.layer_req ^ r_layerAck;
  assign w_anyPending = |w_pending;
  assign w_ctrlIdle   = (bus.sdr_ack == r_sdrReq);

  // Scan from the largest rotation offset down so the nearest pending layer after the last grant wins.
  always_comb begin
    w_grantIdx = r_lastGrant;
    w_rotIdx   = '0;
    for (int k = N_LAYERS; k >= 1; k--) begin
      w_rotIdx = {1'b0, r_lastGrant} + RW'(k);
      if (w_rotIdx >= RW'(N_LAYERS))
        w_rotIdx = w_rotIdx - RW'(N_LAYERS);
      if (w_pending[w_rotIdx[GW-1:0]])
        w_grantIdx = w_rotIdx[GW-1:0];
    end
  end

  always_comb begin
    w_grantAddr = '0;
    for (int i = 0; i < N_LAYERS; i++)
      if (w_grantIdx == GW'(i))
        w_grantAddr = bus.layer_addr[i*AW +: AW];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= IDLE;
    else
      r_state <= w_nextState;
  end

  // A stale ack left over from reset keeps IDLE from granting until the controller catches up.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_anyPending && w_ctrlIdle) w_nextState = WAIT;
      WAIT:    if (w_ctrlIdle)                 w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_doGrant    = 1'b0;
    w_doComplete = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      IDLE: w_doGrant = w_anyPending && w_ctrlIdle;
      WAIT: begin
        w_busy       = 1'b1;
        w_doComplete = w_ctrlIdle;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sdrAddr   <= '0;
      r_sdrReq    <= 1'b0;
      r_grant     <= '0;
      r_lastGrant <= GW'(N_LAYERS - 1);
    end else if (w_doGrant) begin
      r_sdrAddr   <= w_grantAddr;
      r_sdrReq    <= ~r_sdrReq;
      r_grant     <= w_grantIdx;
      r_lastGrant <= w_grantIdx;
    end
  end

  // Only the granted layer's ack and hold register move on completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_layerAck  <= '0;
      r_layerData <= '0;
    end else if (w_doComplete) begin
      for (int i = 0; i < N_LAYERS; i++) begin
        if (r_grant == GW'(i)) begin
          r_layerAck[i]          <= ~r_layerAck[i];
          r_layerData[i*32 +: 32] <= bus.sdr_data;
        end
      end
    end
  end

  assign bus.sdr_addr   = r_sdrAddr;
  assign bus.sdr_req    = r_sdrReq;
  assign bus.layer_ack  = r_layerAck;
  assign bus.layer_data = r_layerData;
  assign bus.busy       = w_busy;

endmodule

// File: tb/tb_ga23_sdr_arbiter.sv
// Directed bench for ga23_sdr_arbiter: inputs change and outputs are sampled on the falling edge.
// The SDRAM model answers each request with a word tagged by the address it was given.
module tb_ga23_sdr_arbiter;

  localparam int N  = 3;
  localparam int AW = 22;

  logic clk = 1'b0;
  logic reset;
  int   compared   = 0;
  int   mismatched = 0;

  ga23_sdr_arbiter_if #(.N_LAYERS(N), .AW(AW)) bus ();
  ga23_sdr_arbiter #(.N_LAYERS(N), .AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [31:0] tagOf(input logic [AW-1:0] a);
    return {10'h2A5, a};
  endfunction

  task automatic doReset();
    reset          = 1'b1;
    bus.layer_req  = '0;
    bus.layer_addr = '0;
    bus.sdr_ack    = 1'b0;
    bus.sdr_data   = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Waits (bounded) for an outstanding request, then acks it lat cycles later; addr is X on timeout.
  task automatic serve(input int lat, output logic [AW-1:0] addr);
    int waited = 0;
    while (bus.sdr_req === bus.sdr_ack && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (bus.sdr_req === bus.sdr_ack) begin
      addr = 'x;
      $display("[TB] no SDRAM request within budget");
    end else begin
      addr = bus.sdr_addr;
      repeat (lat - 1) @(negedge clk);
      bus.sdr_data = tagOf(addr);
      bus.sdr_ack  = ~bus.sdr_ack;
    end
  endtask

  task automatic test_reset();
    doReset();
    compared++; if (bus.sdr_req !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_sdr_req got %b want 0", bus.sdr_req); end
    compared++; if (bus.sdr_addr !== '0) begin mismatched++; $display("[TB] FAIL reset_sdr_addr got %h want 0", bus.sdr_addr); end
    compared++; if (bus.layer_ack !== '0) begin mismatched++; $display("[TB] FAIL reset_layer_ack got %b want 0", bus.layer_ack); end
    compared++; if (bus.layer_data !== '0) begin mismatched++; $display("[TB] FAIL reset_layer_data got %h want 0", bus.layer_data); end
    compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_single();
    doReset();
    bus.layer_addr[1*AW +: AW] = 22'h12345;
    bus.layer_req[1] = 1'b1;
    @(negedge clk);
    compared++; if (bus.sdr_req !== 1'b1) begin mismatched++; $display("[TB] FAIL single_sdr_req got %b want 1", bus.sdr_req); end
    compared++; if (bus.sdr_addr !== 22'h12345) begin mismatched++; $display("[TB] FAIL single_sdr_addr got %h want 12345", bus.sdr_addr); end
    compared++; if (bus.busy !== 1'b1) begin mismatched++; $display("[TB] FAIL single_busy got %b want 1", bus.busy); end
    repeat (4) @(negedge clk);
    compared++; if (bus.sdr_addr !== 22'h12345) begin mismatched++; $display("[TB] FAIL single_addr_hold got %h want 12345", bus.sdr_addr); end
    bus.sdr_data = 32'hDEADBEEF;
    bus.sdr_ack  = 1'b1;
    @(negedge clk);
    compared++; if (bus.layer_ack !== 3'b010) begin mismatched++; $display("[TB] FAIL single_layer_ack got %b want 010", bus.layer_ack); end
    compared++; if (bus.layer_data[1*32 +: 32] !== 32'hDEADBEEF) begin mismatched++; $display("[TB] FAIL single_data1 got %h want deadbeef", bus.layer_data[1*32 +: 32]); end
    compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL single_busy_done got %b want 0", bus.busy); end
    compared++; if (bus.layer_data[0 +: 32] !== 32'h0) begin mismatched++; $display("[TB] FAIL single_data0 got %h want 0", bus.layer_data[0 +: 32]); end
    compared++; if (bus.layer_data[2*32 +: 32] !== 32'h0) begin mismatched++; $display("[TB] FAIL single_data2 got %h want 0", bus.layer_data[2*32 +: 32]); end
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] got;
    logic [AW-1:0] expAddr;
    doReset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++)
        bus.layer_addr[i*AW +: AW] = AW'(32'h100 * (r + 1) + i);
      bus.layer_req = ~bus.layer_req;
      for (int i = 0; i < N; i++) begin
        expAddr = AW'(32'h100 * (r + 1) + i);
        serve(3, got);
        compared++; if (got !== expAddr) begin mismatched++; $display("[TB] FAIL rr_order r%0d s%0d got %h want %h", r, i, got, expAddr); end
        @(negedge clk);
        compared++; if (bus.busy !== 1'b0 || bus.sdr_req !== bus.sdr_ack) begin mismatched++; $display("[TB] FAIL rr_idle_gap r%0d s%0d got busy=%b req=%b want busy=0 req=%b", r, i, bus.busy, bus.sdr_req, bus.sdr_ack); end
      end
      for (int i = 0; i < N; i++) begin
        expAddr = AW'(32'h100 * (r + 1) + i);
        compared++; if (bus.layer_data[i*32 +: 32] !== tagOf(expAddr)) begin mismatched++; $display("[TB] FAIL rr_data r%0d l%0d got %h want %h", r, i, bus.layer_data[i*32 +: 32], tagOf(expAddr)); end
      end
      compared++; if (bus.layer_ack !== ((r == 0) ? 3'b111 : 3'b000)) begin mismatched++; $display("[TB] FAIL rr_ack r%0d got %b", r, bus.layer_ack); end
    end
  endtask

  task automatic test_fairness();
    logic [AW-1:0] got;
    int expLayer [4] = '{0, 1, 2, 0};
    doReset();
    for (int i = 0; i < N; i++)
      bus.layer_addr[i*AW +: AW] = AW'(32'h3000 + i);
    bus.layer_req[0] = 1'b1;
    @(negedge clk);
    bus.layer_req[1] = 1'b1;
    bus.layer_req[2] = 1'b1;
    for (int s = 0; s < 4; s++) begin
      serve(2, got);
      compared++; if (got !== AW'(32'h3000 + expLayer[s])) begin mismatched++; $display("[TB] FAIL fair_grant s%0d got %h want %h", s, got, AW'(32'h3000 + expLayer[s])); end
      @(negedge clk);
      // Layer 0 asks again as soon as its previous fetch is acknowledged.
      if (s < 3 && bus.layer_ack[0] === bus.layer_req[0])
        bus.layer_req[0] = ~bus.layer_req[0];
    end
    compared++; if (bus.layer_ack !== 3'b110) begin mismatched++; $display("[TB] FAIL fair_ack got %b want 110", bus.layer_ack); end
  endtask

  task automatic test_stale_ack();
    logic [AW-1:0] got;
    doReset();
    bus.layer_addr[0 +: AW] = 22'h0ABCD;
    bus.sdr_ack      = 1'b1;
    bus.layer_req[0] = 1'b1;
    repeat (3) @(negedge clk);
    compared++; if (bus.sdr_req !== 1'b0) begin mismatched++; $display("[TB] FAIL stale_no_req got %b want 0", bus.sdr_req); end
    compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL stale_busy got %b want 0", bus.busy); end
    bus.sdr_ack = 1'b0;
    @(negedge clk);
    compared++; if (bus.sdr_req !== 1'b1) begin mismatched++; $display("[TB] FAIL stale_grant got %b want 1", bus.sdr_req); end
    compared++; if (bus.sdr_addr !== 22'h0ABCD) begin mismatched++; $display("[TB] FAIL stale_addr got %h want 0abcd", bus.sdr_addr); end
    serve(1, got);
    @(negedge clk);
    compared++; if (bus.layer_ack !== 3'b001) begin mismatched++; $display("[TB] FAIL stale_ack_done got %b want 001", bus.layer_ack); end
  endtask

  task automatic test_double_toggle();
    logic [AW-1:0] got;
    doReset();
    bus.layer_addr[0 +: AW]    = 22'h00111;
    bus.layer_addr[2*AW +: AW] = 22'h00222;
    bus.layer_req[0] = 1'b1;
    @(negedge clk);
    bus.layer_req[2] = 1'b1;
    @(negedge clk);
    bus.layer_req[2] = 1'b0;
    serve(3, got);
    compared++; if (got !== 22'h00111) begin mismatched++; $display("[TB] FAIL dt_first got %h want 00111", got); end
    repeat (4) @(negedge clk);
    compared++; if (bus.busy !== 1'b0 || bus.sdr_req !== 1'b1) begin mismatched++; $display("[TB] FAIL dt_dropped_req got busy=%b req=%b want busy=0 req=1", bus.busy, bus.sdr_req); end
    compared++; if (bus.layer_ack !== 3'b001) begin mismatched++; $display("[TB] FAIL dt_dropped_ack got %b want 001", bus.layer_ack); end

    bus.layer_req[2] = 1'b1;
    @(negedge clk);
    compared++; if (bus.sdr_req !== 1'b0 || bus.sdr_addr !== 22'h00222) begin mismatched++; $display("[TB] FAIL dt_grant2 got req=%b addr=%h want req=0 addr=00222", bus.sdr_req, bus.sdr_addr); end
    bus.layer_addr[2*AW +: AW] = 22'h00333;
    bus.layer_req[2] = 1'b0;
    serve(2, got);
    compared++; if (got !== 22'h00222) begin mismatched++; $display("[TB] FAIL dt_inflight got %h want 00222", got); end
    @(negedge clk);
    compared++; if (bus.layer_ack[2] !== 1'b1) begin mismatched++; $display("[TB] FAIL dt_ack_mid got %b want 1", bus.layer_ack[2]); end
    compared++; if (bus.layer_data[2*32 +: 32] !== tagOf(22'h00222)) begin mismatched++; $display("[TB] FAIL dt_data_mid got %h want %h", bus.layer_data[2*32 +: 32], tagOf(22'h00222)); end
    serve(2, got);
    compared++; if (got !== 22'h00333) begin mismatched++; $display("[TB] FAIL dt_reissue got %h want 00333", got); end
    @(negedge clk);
    compared++; if (bus.layer_ack !== 3'b001) begin mismatched++; $display("[TB] FAIL dt_ack_end got %b want 001", bus.layer_ack); end
    compared++; if (bus.layer_data[2*32 +: 32] !== tagOf(22'h00333)) begin mismatched++; $display("[TB] FAIL dt_data_end got %h want %h", bus.layer_data[2*32 +: 32], tagOf(22'h00333)); end
    repeat (3) @(negedge clk);
    compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL dt_quiet got %b want 0", bus.busy); end
  endtask

  task automatic test_reset_mid_wait();
    logic [AW-1:0] got;
    doReset();
    bus.layer_addr[0 +: AW]    = 22'h00A00;
    bus.layer_addr[1*AW +: AW] = 22'h000AB;
    bus.layer_addr[2*AW +: AW] = 22'h00C00;
    bus.layer_req[0] = 1'b1;
    bus.layer_req[2] = 1'b1;
    serve(2, got);
    @(negedge clk);
    serve(2, got);
    @(negedge clk);
    compared++; if (bus.layer_ack !== 3'b101) begin mismatched++; $display("[TB] FAIL rmw_pre_ack got %b want 101", bus.layer_ack); end
    bus.layer_req[1] = 1'b1;
    @(negedge clk);
    compared++; if (bus.sdr_req !== 1'b1) begin mismatched++; $display("[TB] FAIL rmw_grant got %b want 1", bus.sdr_req); end
    @(negedge clk);
    #2;
    reset         = 1'b1;
    bus.layer_req = '0;
    #1;
    compared++; if (bus.sdr_req !== 1'b0) begin mismatched++; $display("[TB] FAIL rmw_async_req got %b want 0", bus.sdr_req); end
    compared++; if (bus.sdr_addr !== '0) begin mismatched++; $display("[TB] FAIL rmw_async_addr got %h want 0", bus.sdr_addr); end
    compared++; if (bus.layer_ack !== '0) begin mismatched++; $display("[TB] FAIL rmw_async_ack got %b want 0", bus.layer_ack); end
    compared++; if (bus.layer_data !== '0) begin mismatched++; $display("[TB] FAIL rmw_async_data got %h want 0", bus.layer_data); end
    compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL rmw_async_busy got %b want 0", bus.busy); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    // The controller finally answers the request that reset threw away.
    bus.sdr_data = 32'hBAD0BAD0;
    bus.sdr_ack  = 1'b1;
    bus.layer_addr[2*AW +: AW] = 22'h00C55;
    bus.layer_req[2] = 1'b1;
    repeat (3) @(negedge clk);
    compared++; if (bus.sdr_req !== 1'b0) begin mismatched++; $display("[TB] FAIL rmw_late_blocks got %b want 0", bus.sdr_req); end
    compared++; if (bus.layer_data !== '0) begin mismatched++; $display("[TB] FAIL rmw_late_data got %h want 0", bus.layer_data); end
    bus.sdr_ack = 1'b0;
    @(negedge clk);
    compared++; if (bus.sdr_req !== 1'b1 || bus.sdr_addr !== 22'h00C55) begin mismatched++; $display("[TB] FAIL rmw_regrant got req=%b addr=%h want req=1 addr=00c55", bus.sdr_req, bus.sdr_addr); end
    serve(1, got);
    @(negedge clk);
    compared++; if (bus.layer_data[2*32 +: 32] !== tagOf(22'h00C55)) begin mismatched++; $display("[TB] FAIL rmw_post_data got %h want %h", bus.layer_data[2*32 +: 32], tagOf(22'h00C55)); end
    compared++; if (bus.layer_ack !== 3'b100) begin mismatched++; $display("[TB] FAIL rmw_post_ack got %b want 100", bus.layer_ack); end
  endtask

  initial begin
    reset          = 1'b1;
    bus.layer_req  = '0;
    bus.layer_addr = '0;
    bus.sdr_ack    = 1'b0;
    bus.sdr_data   = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_stale_ack();
    test_double_toggle();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
